// File: rtl/sobel_edge_writer_pkg.sv
// Shared types and helpers for the Sobel edge-map writer.
package edge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    STREAM,
    COL_END,
    FLUSH,
    DONE
  } state_t;

  localparam logic [1:0] EDGE_CODE = 2'b01;
  localparam logic [1:0] BG_CODE   = 2'b00;

  // |Gx|+|Gy| of a 3x3 Sobel window needs three more bits than the pixel.
  function automatic int mag_width(input int pix_w);
    return pix_w + 3;
  endfunction

endpackage

// File: rtl/sobel_edge_writer_if.sv
// Pixel input stream, edge-map BRAM write port and frame control/status.
interface sobel_edge_writer_if #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 8
) ();
  import edge_pkg::*;

  localparam int MAG_W = mag_width(PIX_W);
  localparam int AW    = $clog2(IMG_WIDTH * IMG_HEIGHT);

  logic             start;
  logic [MAG_W-1:0] thresh;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_data;
  logic             in_sof;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [1:0]       wr_data;
  logic             done;
  logic             frame_err;

  // Environment side: supplies pixels and control, observes the writes.
  modport master (
    output start, thresh, in_valid, in_data, in_sof,
    input  in_ready, wr_en, wr_addr, wr_data, done, frame_err
  );

  // Edge writer side.
  modport slave (
    input  start, thresh, in_valid, in_data, in_sof,
    output in_ready, wr_en, wr_addr, wr_data, done, frame_err
  );

endinterface

// File: rtl/sobel_edge_writer_line_buffer.sv
// Two chained row buffers: bank 0 holds row y-1, bank 1 holds row y-2.
// Reads are registered; the caller presents the column it will accept next,
// so the data is waiting when the pixel arrives.
module sobel_line_buffer #(
  parameter int IMG_WIDTH = 640,
  parameter int PIX_W     = 8,
  parameter int XW        = $clog2(IMG_WIDTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [XW-1:0]    wr_addr_i,
  input  logic [XW-1:0]    rd_addr_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [PIX_W-1:0] row1_o,
  output logic [PIX_W-1:0] row2_o
);

  logic [1:0][PIX_W-1:0] rd_w;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [PIX_W-1:0] mem [IMG_WIDTH];
    logic [PIX_W-1:0] rd_q;
    logic [PIX_W-1:0] wdata;

    if (gi == 0) begin : g_head
      assign wdata = pix_i;
    end else begin : g_tail
      // Old content of the bank above moves down one row (read-before-write).
      assign wdata = rd_w[gi-1];
    end

    // Registered read of the prefetched column, write of the accepted column.
    always_ff @(posedge clk) begin
      if (we_i) mem[wr_addr_i] <= wdata;
      rd_q <= mem[rd_addr_i];
    end

    assign rd_w[gi] = rd_q;
  end

  assign row1_o = rd_w[0];
  assign row2_o = rd_w[1];

endmodule

// File: rtl/sobel_edge_writer.sv
// Streaming 3x3 Sobel edge detector writing one 2-bit code per pixel,
// in row-major address order, into the edge-map BRAM.
module sobel_edge_writer
  import edge_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 8
) (
  input logic                clk,
  input logic                rst_n,
  sobel_edge_writer_if.slave bus
);

  localparam int MAG_W = mag_width(PIX_W);
  localparam int SW    = MAG_W + 1;
  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW    = $clog2(NPIX);
  localparam int XW    = $clog2(IMG_WIDTH);
  localparam int YW    = $clog2(IMG_HEIGHT + 1);

  localparam logic [AW-1:0] LAST_ADDR   = AW'(NPIX - 1);
  localparam logic [AW-1:0] LAST_COLEND = AW'((IMG_HEIGHT - 1) * IMG_WIDTH - 1);
  localparam logic [XW-1:0] X_LAST      = XW'(IMG_WIDTH - 1);

  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [MAG_W-1:0]      thresh_q, thresh_d;
  logic                  err_q, err_d;
  // Window columns x-2 and x-1; index 0 = row y-2, 1 = row y-1, 2 = row y.
  logic [2:0][PIX_W-1:0] col0_q, col0_d, col1_q, col1_d;
  logic                  wr_en_q, wr_en_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [1:0]            wr_data_q, wr_data_d;

  logic                  in_ready, done, lb_we;
  logic [PIX_W-1:0]      row1, row2;
  logic [2:0][PIX_W-1:0] new_col;
  logic [SW-1:0]         gx, gy, ax, ay;
  logic                  interior;
  logic [1:0]            edge_code;

  sobel_line_buffer #(
    .IMG_WIDTH (IMG_WIDTH),
    .PIX_W     (PIX_W),
    .XW        (XW)
  ) u_lb (
    .clk       (clk),
    .we_i      (lb_we),
    .wr_addr_i (x_q),
    .rd_addr_i (x_d),
    .pix_i     (bus.in_data),
    .row1_o    (row1),
    .row2_o    (row2)
  );

  // Weighted column/row sum a + 2b + c, widened so differences stay signed.
  function automatic logic [SW-1:0] wsum(input logic [PIX_W-1:0] a,
                                         input logic [PIX_W-1:0] b,
                                         input logic [PIX_W-1:0] c);
    return SW'(a) + (SW'(b) << 1) + SW'(c);
  endfunction

  // Sobel magnitude and threshold for the window centred at (x-1, y-1).
  always_comb begin
    new_col   = {bus.in_data, row1, row2};
    gx        = wsum(new_col[0], new_col[1], new_col[2]) - wsum(col0_q[0], col0_q[1], col0_q[2]);
    gy        = wsum(col0_q[2], col1_q[2], new_col[2]) - wsum(col0_q[0], col1_q[0], new_col[0]);
    ax        = gx[SW-1] ? (~gx + SW'(1)) : gx;
    ay        = gy[SW-1] ? (~gy + SW'(1)) : gy;
    // Centre column W-1 and row H-1 never reach this path, so only the
    // leading border needs masking.
    interior  = (x_q >= XW'(2)) && (y_q >= YW'(2));
    edge_code = (interior && ((ax + ay) >= {1'b0, thresh_q})) ? EDGE_CODE : BG_CODE;
  end

  // Frame sequencing, pixel acceptance and write issue.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    thresh_d  = thresh_q;
    err_d     = err_q;
    col0_d    = col0_q;
    col1_d    = col1_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = BG_CODE;
    in_ready  = 1'b0;
    done      = 1'b0;
    lb_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          thresh_d = bus.thresh;
          err_d    = 1'b0;
          x_d      = '0;
          y_d      = '0;
          cnt_d    = '0;
          state_d  = WAIT_SOF;
        end
      end
      WAIT_SOF: begin
        in_ready = 1'b1;
        if (bus.in_valid && bus.in_sof) begin
          col0_d  = col1_q;
          col1_d  = new_col;
          lb_we   = 1'b1;
          x_d     = XW'(1);
          state_d = STREAM;
        end
      end
      STREAM: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          if (bus.in_sof) err_d = 1'b1;
          col0_d = col1_q;
          col1_d = new_col;
          lb_we  = 1'b1;
          if (x_q != '0 && y_q != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = edge_code;
            cnt_d     = cnt_q + AW'(1);
          end
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
            if (y_q != '0) state_d = COL_END;
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      COL_END: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        cnt_d     = cnt_q + AW'(1);
        state_d   = (cnt_q == LAST_COLEND) ? FLUSH : STREAM;
      end
      FLUSH: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == LAST_ADDR) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!bus.start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, window and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      thresh_q  <= '0;
      err_q     <= 1'b0;
      col0_q    <= '0;
      col1_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= BG_CODE;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      thresh_q  <= thresh_d;
      err_q     <= err_d;
      col0_q    <= col0_d;
      col1_q    <= col1_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.done      = done;
  assign bus.frame_err = err_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_sobel_edge_writer.sv
// Frame-level bench for sobel_edge_writer on an 8x6 image: drives frames,
// collects every BRAM write and compares against a direct Sobel model.
module tb_sobel_edge_writer;
  import edge_pkg::*;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int P    = 8;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sobel_edge_writer_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(P)) bus ();

  sobel_edge_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int img [NPIX];
  int wa_q [$];
  int wd_q [$];
  int ready_low;
  int done_last;
  bit counting = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Write monitor and in_ready stall counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && bus.wr_en) begin
      wa_q.push_back(int'(bus.wr_addr));
      wd_q.push_back(int'(bus.wr_data));
      if (int'(bus.wr_addr) == NPIX - 1) done_last = int'(bus.done);
    end
    if (counting && !bus.in_ready && !bus.done) ready_low++;
  end

  // Reference: code for pixel a computed straight from the image.
  function automatic int exp_code(input int a, input int th);
    int x, y, gx, gy;
    x = a % W;
    y = a / W;
    if (x == 0 || y == 0 || x == W - 1 || y == H - 1) return 0;
    gx = 0;
    gy = 0;
    for (int k = -1; k <= 1; k++) begin
      int wt;
      wt = (k == 0) ? 2 : 1;
      gx += wt * (img[(y + k) * W + x + 1] - img[(y + k) * W + x - 1]);
      gy += wt * (img[(y + 1) * W + x + k] - img[(y - 1) * W + x + k]);
    end
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return (gx + gy >= th) ? 1 : 0;
  endfunction

  task automatic fill(input int kind);
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0:       img[i] = 0;
        1:       img[i] = (i % W >= 4) ? 255 : 0;
        2:       img[i] = (i == 3 * W + 3) ? 10 : 0;
        3:       img[i] = int'($urandom_range(0, 255));
        default: img[i] = int'($urandom_range(100, 115));
      endcase
    end
  endtask

  // One pixel handshake, optionally preceded by an idle gap.
  task automatic push(input int d, input bit sof, input int gap_pct);
    int guard;
    bit acc;
    if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(d);
    bus.in_sof   = sof;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check("push_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic run_frame(input string name, input int th, input int gap_pct,
                           input int n_drop, input int sof_mid, input int exp_err);
    int n;
    int edges;
    wa_q.delete();
    wd_q.delete();
    ready_low    = 0;
    done_last    = 0;
    bus.thresh   = 11'(th);
    bus.start    = 1'b1;
    for (int i = 0; i < n_drop; i++) push(int'($urandom_range(0, 255)), 1'b0, 0);
    for (int i = 0; i < NPIX; i++) begin
      push(img[i], (i == 0) || (i == sof_mid), gap_pct);
      if (i == 0) counting = 1'b1;
    end
    n = 0;
    while (!bus.done && n < 500) begin
      @(negedge clk);
      n++;
    end
    #1;
    counting = 1'b0;
    check({name, ":done_seen"}, 32'(bus.done), 32'd1);
    check({name, ":n_writes"}, 32'(wa_q.size()), 32'(NPIX));
    edges = 0;
    for (int i = 0; i < wa_q.size() && i < NPIX; i++) begin
      check($sformatf("%s:wr_addr[%0d]", name, i), 32'(wa_q[i]), 32'(i));
      check($sformatf("%s:wr_data[%0d]", name, i), 32'(wd_q[i]), 32'(exp_code(i, th)));
      edges += wd_q[i];
    end
    check({name, ":done_with_last"}, 32'(done_last), 32'd1);
    check({name, ":frame_err"}, 32'(bus.frame_err), 32'(exp_err));
    check({name, ":ready_low"}, 32'(ready_low), 32'((H - 1) + W));
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check({name, ":done_drop"}, 32'(bus.done), 32'd0);
    check({name, ":idle_ready"}, 32'(bus.in_ready), 32'd0);
    $display("frame %s thresh=%0d writes=%0d edges=%0d err=%0d",
             name, th, wa_q.size(), edges, bus.frame_err);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ":in_ready"}, 32'(bus.in_ready), 32'd0);
    check({name, ":wr_en"}, 32'(bus.wr_en), 32'd0);
    check({name, ":wr_addr"}, 32'(bus.wr_addr), 32'd0);
    check({name, ":wr_data"}, 32'(bus.wr_data), 32'd0);
    check({name, ":done"}, 32'(bus.done), 32'd0);
    check({name, ":frame_err"}, 32'(bus.frame_err), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.thresh   = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sof   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fill(0); run_frame("zero", 1, 0, 0, -1, 0);
    fill(1); run_frame("step", 100, 0, 0, -1, 0);
    fill(2); run_frame("dot_t20", 20, 0, 0, -1, 0);
    fill(2); run_frame("dot_t21", 21, 0, 0, -1, 0);
    fill(1); run_frame("step_gaps", 100, 30, 0, -1, 0);
    fill(3); run_frame("drop_sof", int'($urandom_range(0, 2040)), 0, 3, 20, 1);
    fill(3); run_frame("rand_gaps", int'($urandom_range(0, 2040)), 25, 0, -1, 0);
    fill(4); run_frame("smooth", int'($urandom_range(0, 60)), 20, 0, -1, 0);

    // Reset in the middle of a frame, then a clean frame.
    fill(1);
    bus.thresh = 11'd100;
    bus.start  = 1'b1;
    for (int i = 0; i < 30; i++) push(img[i], i == 0, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midreset_hold");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame("after_reset", 100, 0, 0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
